// File: rtl/step_ctrl_pkg.sv
// Shared types and default timing constants for the single-step controller.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PRESS_WAIT = 2'd1,
        S_HELD       = 2'd2,
        S_REL_WAIT   = 2'd3
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;   // 10 ms at 50 MHz
    localparam int RUN_DIV_DEF         = 25000000; // 2 Hz at 50 MHz

endpackage

// File: rtl/step_ctrl_sync2.sv
// Generic two-flop synchronizer with a configurable reset value, shared by
// the KEY/SW input paths.
module sync2 #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/step_ctrl.sv
// Single-step controller: debounces KEY[1] into a one-cycle CPU advance
// enable, with an optional free-run divider and a wrapping step counter.
//
// state        | meaning
// S_IDLE       | button released and stable
// S_PRESS_WAIT | low seen, waiting for press to stay stable
// S_HELD       | press accepted, button held
// S_REL_WAIT   | high seen, waiting for release to stay stable
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int RUN_DIV         = RUN_DIV_DEF,
    parameter int CNT_W           = 16
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             key_n,
    input  logic             run_en,
    output logic             step_pulse,
    output logic             pressed,
    output logic [CNT_W-1:0] step_count
);

    localparam int                DCNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int                DIV_W   = $clog2(RUN_DIV);
    localparam logic [DCNT_W-1:0] DCNT_TC = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_TC  = DIV_W'(RUN_DIV - 1);

    logic ks;

    state_t            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              step_pulse_q, step_pulse_d;
    logic              pressed_q, pressed_d;
    logic [CNT_W-1:0]  step_count_q, step_count_d;
    logic              accept;
    logic              run_pulse;

    sync2 #(
        .W       (1),
        .RST_VAL (1'b1)
    ) u_key_sync (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .din   (key_n),
        .dout  (ks)
    );

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!ks) begin
                    state_d = S_PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (ks) begin
                    state_d = S_IDLE;
                end else if (dcnt_q == DCNT_TC) begin
                    state_d = S_HELD;
                    accept  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            S_HELD: begin
                if (ks) begin
                    state_d = S_REL_WAIT;
                    dcnt_d  = '0;
                end
            end
            S_REL_WAIT: begin
                if (!ks) begin
                    state_d = S_HELD;
                end else if (dcnt_q == DCNT_TC) begin
                    state_d = S_IDLE;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                dcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        div_d     = '0;
        run_pulse = 1'b0;
        if (run_en) begin
            if (div_q == DIV_TC) begin
                run_pulse = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Masking with the current pulse keeps the enable strictly single-cycle
    // even when a divider pulse is followed by a press on the run_en falling edge.
    always_comb begin
        step_pulse_d = (run_en ? run_pulse : accept) & ~step_pulse_q;
        pressed_d    = (state_d == S_HELD) || (state_d == S_REL_WAIT);
        step_count_d = step_pulse_q ? step_count_q + CNT_W'(1) : step_count_q;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dcnt_q       <= '0;
            div_q        <= '0;
            step_pulse_q <= 1'b0;
            pressed_q    <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            div_q        <= div_d;
            step_pulse_q <= step_pulse_d;
            pressed_q    <= pressed_d;
            step_count_q <= step_count_d;
        end
    end

    assign step_pulse = step_pulse_q;
    assign pressed    = pressed_q;
    assign step_count = step_count_q;

endmodule

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
- Single-step controller placed directly upstream of cpu_top's datapath.
- Turns the raw, bouncy active-low push-button KEY[1] into a clean one-cycle `step_pulse` clock-enable on CLOCK_50.
- The CPU advances exactly one instruction per pulse.
- Also provides a free-run mode (periodic pulses) and a wrap-around step counter for the HEX debug display mux.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles `key_n` must stay stable before a press/release is accepted (10 ms @ 50 MHz); must be ≥ 2.
- RUN_DIV, 25000000: pulse period in free-run mode, in cycles (2 Hz); must be ≥ 2.
- CNT_W, 16: width of `step_count`.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset (driven from KEY[0]).
- key_n  in  1  raw KEY[1]; 0 = pressed; asynchronous to CLOCK_50.
- run_en  in  1  1 = free-run mode; synchronous, glitch-free level.
- step_pulse  out  1  one-cycle CPU advance enable; registered.
- pressed  out  1  debounced button level; 1 = held.
- step_count  out  CNT_W  number of step_pulse assertions since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0):
  - synchronizer flops = 1; FSM = S_IDLE; debounce counter = 0; divider = 0.
  - step_pulse = 0; pressed = 0; step_count = 0.
  - Applies immediately, including mid-debounce or mid-pulse. No pulse is produced on reset release.
- Synchronizer: 2 flops on key_n; FSM uses only the output `ks`.
- FSM states, using counter `dcnt`:
  - S_IDLE: ks=0 → S_PRESS_WAIT, dcnt←0.
  - S_PRESS_WAIT:
    - ks=1 → S_IDLE (glitch rejected, no pulse).
    - ks=0 and dcnt==DEBOUNCE_CYCLES-1 → S_HELD, and step_pulse←1 when run_en=0.
    - Otherwise dcnt++.
  - S_HELD: ks=1 → S_REL_WAIT, dcnt←0.
  - S_REL_WAIT:
    - ks=0 → S_HELD (release bounce ignored).
    - ks=1 and dcnt==DEBOUNCE_CYCLES-1 → S_IDLE.
    - Otherwise dcnt++.
- pressed = 1 in S_HELD or S_REL_WAIT; registered/state-decoded, no glitches.
- Manual latency:
  - Count the first rising edge that samples key_n=0 as edge 1, with key_n held low from then on.
  - step_pulse is high during the cycle after edge DEBOUNCE_CYCLES+3, for exactly one cycle.
- Exactly one pulse per accepted press. Holding the button never repeats. A new pulse requires the full release debounce and then a new press debounce.
- Free-run (run_en=1):
  - Divider counts 0..RUN_DIV-1 and wraps.
  - step_pulse←1 on the edge where the divider == RUN_DIV-1, giving a period of exactly RUN_DIV cycles.
  - First pulse comes RUN_DIV cycles after run_en is sampled high.
  - Manual presses still update the FSM and `pressed` but produce no pulse.
- run_en 1→0: divider cleared to 0 on the next edge; no pulse that cycle. Manual mode resumes immediately.
- A press accepted on the same edge that run_en goes 0 does pulse, because the run_en value sampled on that edge governs.
- step_pulse is never high on two consecutive cycles in either mode.
- step_count increments on the edge after each step_pulse=1 cycle and wraps from 2^CNT_W-1 to 0.
- Counter widths: dcnt is $clog2(DEBOUNCE_CYCLES) bits; divider is $clog2(RUN_DIV) bits; no overflow past terminal.

Decomposition:
- Package step_ctrl_pkg:
  - state enum state_t {S_IDLE, S_PRESS_WAIT, S_HELD, S_REL_WAIT} (2-bit).
  - default constants DEBOUNCE_CYCLES_DEF and RUN_DIV_DEF.
- One sub-module, sync2: a generic 2-flop synchronizer with parameterised reset value, async active-low reset. It is reused for other KEY/SW inputs.
- Everything else is in step_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=5, CNT_W=4):
- Reset: rst_n=0 for 3 cycles with key_n=0 → step_pulse=0, pressed=0, step_count=0. Release reset with key_n held 0 → first pulse in the cycle after edge 7 (edge 1 = first post-reset edge), step_count=1 after it.
- Clean press: key_n low for 20 cycles, then high → exactly one step_pulse in the cycle after edge 7; pressed=1 from then until 6 cycles after the release edge; step_count=1.
- Bounce: key_n low 2 cycles, high 1, low 1, high 2, then low 10 → only one pulse, 7 edges after the final falling sample; step_count=1. A 2-cycle glitch alone → no pulse, pressed stays 0.
- Free-run: run_en=1 for 27 cycles, key_n=1 → pulses every 5 cycles, 5 pulses total, step_count=5. Then run_en=0 → no further pulses.
- Wrap: 16 clean presses → step_count returns to 0 after the 16th pulse.
- Async reset mid-debounce: assert rst_n=0 at dcnt=2 (between clock edges) → outputs clear immediately, no pulse until a full new debounce completes.
